// File: rtl/sprite_fetch.sv
// Sprite fetch stage: per-pixel inside test, SRAM address generation, texel
// realignment, colour keying and per-frame opaque-pixel counting.
module sprite_fetch #(
    parameter int                    DATA_WIDTH = 12,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    COORD_W    = 10,
    parameter int                    SPR_W      = 64,
    parameter int                    SPR_H      = 64,
    parameter int                    BASE_ADDR  = 0,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 12'h0F0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [COORD_W-1:0]    pos_x_i,
    input  logic [COORD_W-1:0]    pos_y_i,
    input  logic                  flip_i,
    input  logic [COORD_W-1:0]    pixel_x,
    input  logic [COORD_W-1:0]    pixel_y,
    input  logic                  pixel_valid,
    output logic                  sram_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_data,
    output logic [DATA_WIDTH-1:0] rgb_o,
    output logic                  opaque_o,
    output logic                  valid_o,
    output logic [15:0]           opaque_cnt_o
);

    logic [COORD_W-1:0]    r_pos_x;
    logic [COORD_W-1:0]    r_pos_y;
    logic                  r_flip;
    logic                  r_sram_en;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic                  r_inside1;
    logic                  r_valid1;
    logic                  r_inside2;
    logic                  r_valid2;
    logic [DATA_WIDTH-1:0] r_rgb;
    logic                  r_opaque;
    logic                  r_valid;
    logic [15:0]           r_cnt;
    logic [15:0]           r_cnt_out;

    logic [COORD_W:0]      w_dx;
    logic [COORD_W:0]      w_dy;
    logic [31:0]           w_dx32;
    logic [31:0]           w_dy32;
    logic                  w_inside;
    logic [31:0]           w_lx;
    logic [31:0]           w_addr_full;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_opaque_next;
    logic [15:0]           w_cnt_inc;

    // A negative difference shows up as the extra MSB being set.
    assign w_dx     = {1'b0, pixel_x} - {1'b0, r_pos_x};
    assign w_dy     = {1'b0, pixel_y} - {1'b0, r_pos_y};
    assign w_dx32   = 32'(w_dx);
    assign w_dy32   = 32'(w_dy);
    assign w_inside = pixel_valid & ~w_dx[COORD_W] & ~w_dy[COORD_W]
                    & (w_dx32 < 32'(SPR_W)) & (w_dy32 < 32'(SPR_H));

    // Mirrored lx is only meaningful when inside; outside the address is forced to 0.
    assign w_lx        = r_flip ? (32'(SPR_W - 1) - w_dx32) : w_dx32;
    assign w_addr_full = 32'(BASE_ADDR) + (w_dy32 * 32'(SPR_W)) + w_lx;
    assign w_addr      = w_addr_full[ADDR_WIDTH-1:0];

    assign w_opaque_next = r_inside2 & (sram_data != KEY_COLOR);
    assign w_cnt_inc     = (r_opaque && (r_cnt != 16'hFFFF)) ? (r_cnt + 16'd1) : r_cnt;

    // Shadow-to-active latch and the three pipeline stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos_x     <= '0;
            r_pos_y     <= '0;
            r_flip      <= 1'b0;
            r_sram_en   <= 1'b0;
            r_sram_addr <= '0;
            r_inside1   <= 1'b0;
            r_valid1    <= 1'b0;
            r_inside2   <= 1'b0;
            r_valid2    <= 1'b0;
            r_rgb       <= '0;
            r_opaque    <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (frame_start) begin
                r_pos_x <= pos_x_i;
                r_pos_y <= pos_y_i;
                r_flip  <= flip_i;
            end else begin
                r_pos_x <= r_pos_x;
                r_pos_y <= r_pos_y;
                r_flip  <= r_flip;
            end
            r_sram_en   <= w_inside;
            r_sram_addr <= w_inside ? w_addr : '0;
            r_inside1   <= w_inside;
            r_valid1    <= pixel_valid;
            r_inside2   <= r_inside1;
            r_valid2    <= r_valid1;
            r_opaque    <= w_opaque_next;
            r_rgb       <= w_opaque_next ? sram_data : '0;
            r_valid     <= r_valid2;
        end
    end

    // Opaque counter; a frame boundary publishes the count including this cycle's pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 16'd0;
            r_cnt_out <= 16'd0;
        end else if (frame_start) begin
            r_cnt     <= 16'd0;
            r_cnt_out <= w_cnt_inc;
        end else begin
            r_cnt     <= w_cnt_inc;
            r_cnt_out <= r_cnt_out;
        end
    end

    assign sram_en      = r_sram_en;
    assign sram_addr    = r_sram_addr;
    assign rgb_o        = r_rgb;
    assign opaque_o     = r_opaque;
    assign valid_o      = r_valid;
    assign opaque_cnt_o = r_cnt_out;

endmodule

// File: doc/sprite_fetch.md
# sprite_fetch

Per-pixel sprite fetch stage that sits directly upstream of an image SRAM holding one sprite, and directly downstream of the VGA timing generator. For each active screen pixel it decides whether the pixel falls inside the sprite rectangle, issues the SRAM read address, and realigns the returned texel with its pixel. It then applies the colour key and presents an RGB value plus an opaque flag to the compositor. Sprite position and flip are double-buffered so that they change only at frame boundaries.

## Interface

Parameters:
- DATA_WIDTH, 12: texel width (RGB 4:4:4); matches SRAM data width.
- ADDR_WIDTH, 16: SRAM address width.
- COORD_W, 10: screen coordinate width.
- SPR_W, 64: sprite width in texels (any value ≥1).
- SPR_H, 64: sprite height in texels (any value ≥1).
- BASE_ADDR, 0: SRAM address of texel (0,0).
- KEY_COLOR, 12'h0F0: transparent colour.

Ports:
- clk  in  1  single clock; all logic rises on posedge clk.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank; latches shadow registers.
- pos_x_i  in  COORD_W  sprite left edge, shadow value.
- pos_y_i  in  COORD_W  sprite top edge, shadow value.
- flip_i  in  1  horizontal mirror, shadow value.
- pixel_x  in  COORD_W  current screen column.
- pixel_y  in  COORD_W  current screen row.
- pixel_valid  in  1  pixel_x/pixel_y are an active-video pixel.
- sram_en  out  1  read enable to SRAM; SRAM write enable is tied low outside this block.
- sram_addr  out  ADDR_WIDTH  SRAM read address.
- sram_data  in  DATA_WIDTH  SRAM registered read data; valid one clock after the address is presented.
- rgb_o  out  DATA_WIDTH  sprite colour; 0 when not opaque.
- opaque_o  out  1  pixel is inside the sprite and not KEY_COLOR.
- valid_o  out  1  delayed pixel_valid, aligned with rgb_o/opaque_o.
- opaque_cnt_o  out  16  opaque pixel count of the previous frame.

## Operation

- Active registers pos_x, pos_y, flip are loaded from the *_i inputs on any cycle with frame_start=1. Reset values are 0, 0, 0.
- A pixel sampled in the same cycle as frame_start uses the old active values.
- Inside test, stage 1:
  - dx = {1'b0,pixel_x} − {1'b0,pos_x} and dy likewise, computed at COORD_W+1 bits.
  - inside = pixel_valid & ~dx[MSB] & ~dy[MSB] & dx<SPR_W & dy<SPR_H.
  - Sprites clip naturally at the right and bottom edges.
- Texel coordinates: lx = flip ? SPR_W−1−dx : dx; ly = dy.
- addr = BASE_ADDR + ly*SPR_W + lx, truncated to ADDR_WIDTH. SPR_W is a constant, so no general multiplier is needed.
- The integrator guarantees BASE_ADDR + SPR_W*SPR_H ≤ 2^ADDR_WIDTH.
- Registered stage-1 outputs:
  - sram_en = inside.
  - sram_addr = addr when inside, else 0.
  - Internal flags inside1 and valid1.
- Stage 2 (while SRAM produces data): inside2 = inside1, valid2 = valid1.
- Output stage, registered:
  - opaque_o = inside2 & (sram_data ≠ KEY_COLOR).
  - rgb_o = opaque_o_next ? sram_data : 0.
  - valid_o = valid2.
- Opaque counter:
  - Internal cnt increments on each opaque_o=1 cycle and saturates at 16'hFFFF.
  - On frame_start, opaque_cnt_o ← cnt (including any increment landing in that same cycle) and cnt clears to 0.
- Reset: every output and pipeline register goes to 0, and the active registers go to 0. Reset has priority over frame_start.

## Timing

- Latency: pixel sampled at edge k → sram_en/sram_addr valid after edge k → sram_data valid after edge k+1 → rgb_o/opaque_o/valid_o valid after edge k+2. Fixed 2-clock latency, no stalls, one pixel per clock.
- There is no handshake. The downstream compositor delays its own pixel coordinates by 2 clocks.
- Reset mid-frame: outputs are 0 after the reset edge, and the pipeline is flushed. The first valid output is the first pixel sampled after reset deasserts, 2 clocks later.
- frame_start during active video is legal. The new position applies to pixels sampled from the next cycle on.

## Test plan

- Reset then idle: hold reset 3 cycles, then pixel_valid=0 → all outputs 0, opaque_cnt_o=0.
- Basic fetch: pos=(100,50), flip=0, frame_start, then pixel (100,50) → sram_addr=0 after 1 clk; pixel (103,51) → sram_addr=67. SRAM model returns 12'hF00 → rgb_o=12'hF00, opaque_o=1, two clocks after each sample.
- Flip and edges:
  - flip=1, pixel (100,50) → sram_addr=63.
  - Pixel (164,50), dx=64 → sram_en=0, opaque_o=0.
  - Pixel (99,50) → sram_en=0 (negative dx).
- Colour key: SRAM returns 12'h0F0 inside the sprite → opaque_o=0, rgb_o=0, valid_o=1.
- Double buffer: change pos_x_i to 200 mid-frame with no frame_start → pixel (100,50) still hits. After a frame_start, pixel (100,50) misses and pixel (200,50) hits.
- Counter: frame with 10 opaque pixels, then frame_start → opaque_cnt_o=10 and internal count restarts. Assert reset during a burst → valid_o=0 the next cycle and opaque_cnt_o=0.
